// File: rtl/promo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | promo_pkg : shared state and piece encodings, wrap helpers   |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
package promo_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SELECT  = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [2:0] PC_PAWN   = 3'd0;
  localparam logic [2:0] PC_QUEEN  = 3'd1;
  localparam logic [2:0] PC_KNIGHT = 3'd2;
  localparam logic [2:0] PC_ROOK   = 3'd3;
  localparam logic [2:0] PC_BISHOP = 3'd4;

  // Candidate cycle skips the pawn: queen..bishop only.
  function automatic logic [2:0] next_piece(input logic [2:0] p);
    return (p >= PC_BISHOP) ? PC_QUEEN : p + 3'd1;
  endfunction

  function automatic logic [2:0] prev_piece(input logic [2:0] p);
    return (p <= PC_QUEEN) ? PC_BISHOP : p - 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------+
// | key_edge_detect : per-key register and rising-edge output    |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module key_edge_detect #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] key_d;

  always_comb key_d = key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= '0;
    else     key_q <= key_d;
  end

  assign rise = key & ~key_q;

endmodule
`default_nettype wire

// File: rtl/promo_select_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------+
// | promo_select_ctrl : pawn-promotion piece chooser and commit  |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module promo_select_ctrl
  import promo_pkg::*;
#(
  parameter int BLINK_FRAMES = 15
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       promo_req,
  input  logic [5:0] promo_square,
  input  logic       key_next,
  input  logic       key_prev,
  input  logic       key_confirm,
  output logic [2:0] promotion,
  output logic       preview_on,
  output logic       busy,
  output logic       promo_done,
  output logic [2:0] promo_piece,
  output logic [5:0] promo_square_out
);

  localparam logic [7:0] c_blink_last = 8'(BLINK_FRAMES - 1);

  logic [2:0] w_rise;
  logic       w_next_rise;
  logic       w_prev_rise;
  logic       w_conf_rise;

  key_edge_detect #(.WIDTH(3)) u_keys (
    .clk  (vga_clk),
    .rst  (Reset),
    .key  ({key_confirm, key_prev, key_next}),
    .rise (w_rise)
  );

  assign w_next_rise = w_rise[0];
  assign w_prev_rise = w_rise[1];
  assign w_conf_rise = w_rise[2];

  logic [1:0] state_q,     state_d;
  logic [2:0] choice_q,    choice_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       preview_q,   preview_d;
  logic       done_q,      done_d;
  logic [2:0] piece_q,     piece_d;
  logic [5:0] square_q,    square_d;
  logic [2:0] promotion_q, promotion_d;
  logic       busy_q,      busy_d;

  always_comb begin
    state_d     = state_q;
    choice_d    = choice_q;
    blink_cnt_d = blink_cnt_q;
    preview_d   = 1'b1;
    piece_d     = piece_q;
    square_d    = square_q;

    case (state_q)
      ST_IDLE: begin
        if (promo_req) begin
          square_d    = promo_square;
          choice_d    = PC_QUEEN;
          blink_cnt_d = 8'd0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        preview_d = preview_q;
        if (w_conf_rise) begin
          state_d   = ST_COMMIT;
          piece_d   = choice_q;
          preview_d = 1'b1;
        end else if (w_next_rise ^ w_prev_rise) begin
          choice_d    = w_next_rise ? next_piece(choice_q) : prev_piece(choice_q);
          blink_cnt_d = 8'd0;
          preview_d   = 1'b1;
        end else if (frame_tick) begin
          if (blink_cnt_q == c_blink_last) begin
            blink_cnt_d = 8'd0;
            preview_d   = ~preview_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
        end
      end
      ST_COMMIT: state_d = ST_RELEASE;
      ST_RELEASE: begin
        // Hold off re-arming until every key is up so a held key cannot leak
        // into the next promotion.
        if (!(key_next || key_prev || key_confirm)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    done_d      = (state_d == ST_COMMIT);
    busy_d      = (state_d != ST_IDLE);
    promotion_d = (state_d != ST_IDLE) ? choice_d : PC_PAWN;
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      choice_q    <= PC_QUEEN;
      blink_cnt_q <= 8'd0;
      preview_q   <= 1'b1;
      done_q      <= 1'b0;
      piece_q     <= PC_PAWN;
      square_q    <= 6'd0;
      promotion_q <= PC_PAWN;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      choice_q    <= choice_d;
      blink_cnt_q <= blink_cnt_d;
      preview_q   <= preview_d;
      done_q      <= done_d;
      piece_q     <= piece_d;
      square_q    <= square_d;
      promotion_q <= promotion_d;
      busy_q      <= busy_d;
    end
  end

  assign promotion        = promotion_q;
  assign preview_on       = preview_q;
  assign busy             = busy_q;
  assign promo_done       = done_q;
  assign promo_piece      = piece_q;
  assign promo_square_out = square_q;

endmodule
`default_nettype wire

// File: tb/tb_promo_select_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_promo_select_ctrl : scoreboard bench, BLINK_FRAMES = 2    |
// | rev 1.0                                                      |
// +--------------------------------------------------------------+
module tb_promo_select_ctrl;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       promo_req = 1'b0;
  logic [5:0] promo_square = 6'd0;
  logic       key_next = 1'b0;
  logic       key_prev = 1'b0;
  logic       key_confirm = 1'b0;
  logic [2:0] promotion;
  logic       preview_on;
  logic       busy;
  logic       promo_done;
  logic [2:0] promo_piece;
  logic [5:0] promo_square_out;

  promo_select_ctrl #(.BLINK_FRAMES(2)) dut (
    .vga_clk          (vga_clk),
    .Reset            (Reset),
    .frame_tick       (frame_tick),
    .promo_req        (promo_req),
    .promo_square     (promo_square),
    .key_next         (key_next),
    .key_prev         (key_prev),
    .key_confirm      (key_confirm),
    .promotion        (promotion),
    .preview_on       (preview_on),
    .busy             (busy),
    .promo_done       (promo_done),
    .promo_piece      (promo_piece),
    .promo_square_out (promo_square_out)
  );

  always #5 vga_clk = ~vga_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];

  // Packed view: {promotion, preview_on, busy, promo_done, promo_piece, square}
  function automatic logic [14:0] pk(input int prom, input int prev, input int bsy,
                                     input int done, input int piece, input int sq);
    return {3'(prom), 1'(prev), 1'(bsy), 1'(done), 3'(piece), 6'(sq)};
  endfunction

  localparam logic [14:0] c_rst_vals = 15'({3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 6'd0});

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got prom=%0d prev=%0d busy=%0d done=%0d piece=%0d sq=%0d, expected prom=%0d prev=%0d busy=%0d done=%0d piece=%0d sq=%0d",
               tag, got[14:12], got[11], got[10], got[9], got[8:6], got[5:0],
               exp[14:12], exp[11], exp[10], exp[9], exp[8:6], exp[5:0]);
    end
  endtask

  task automatic push_exp(input string tag, input logic [14:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic retire();
    logic [14:0] obs;
    obs = {promotion, preview_on, busy, promo_done, promo_piece, promo_square_out};
    check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic step(input string tag, input logic [14:0] e);
    push_exp(tag, e);
    @(posedge vga_clk);
    #1;
    retire();
  endtask

  int nexts [4] = '{2, 3, 4, 1};
  int blinks[7] = '{1, 0, 0, 1, 1, 0, 0};

  initial begin
    #12;
    step("reset", c_rst_vals);
    Reset = 1'b0;
    step("idle", c_rst_vals);

    promo_square = 6'd56; promo_req = 1'b1;
    step("req", pk(1, 1, 1, 0, 0, 56));
    promo_req = 1'b0; promo_square = 6'd0;

    foreach (nexts[i]) begin
      key_next = 1'b1; step("next", pk(nexts[i], 1, 1, 0, 0, 56));
      key_next = 1'b0; step("next_rel", pk(nexts[i], 1, 1, 0, 0, 56));
    end
    key_prev = 1'b1; step("prev", pk(4, 1, 1, 0, 0, 56));
    key_prev = 1'b0; step("prev_rel", pk(4, 1, 1, 0, 0, 56));
    key_next = 1'b1; key_prev = 1'b1; step("both", pk(4, 1, 1, 0, 0, 56));
    key_next = 1'b0; key_prev = 1'b0; step("both_rel", pk(4, 1, 1, 0, 0, 56));

    frame_tick = 1'b1;
    foreach (blinks[i]) step("blink", pk(4, blinks[i], 1, 0, 0, 56));
    frame_tick = 1'b0;
    // Counter sits at 1 with preview low; a press must clear both.
    key_next = 1'b1; step("blink_press", pk(1, 1, 1, 0, 0, 56));
    key_next = 1'b0; frame_tick = 1'b1;
    step("blink_cleared", pk(1, 1, 1, 0, 0, 56));
    step("blink_toggle", pk(1, 0, 1, 0, 0, 56));
    frame_tick = 1'b0;

    key_next = 1'b1; step("to_knight", pk(2, 1, 1, 0, 0, 56));
    key_next = 1'b0; step("to_knight_rel", pk(2, 1, 1, 0, 0, 56));
    key_next = 1'b1; step("to_rook", pk(3, 1, 1, 0, 0, 56));
    key_next = 1'b0; step("to_rook_rel", pk(3, 1, 1, 0, 0, 56));

    key_confirm = 1'b1;
    step("commit", pk(3, 1, 1, 1, 3, 56));
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin promo_req = 1'b1; promo_square = 6'd10; end
      step("release_hold", pk(3, 1, 1, 0, 3, 56));
      promo_req = 1'b0; promo_square = 6'd0;
    end
    key_confirm = 1'b0;
    step("back_idle", pk(0, 1, 0, 0, 3, 56));

    promo_square = 6'd7; promo_req = 1'b1;
    step("req2", pk(1, 1, 1, 0, 3, 7));
    promo_req = 1'b0; promo_square = 6'd0;
    key_next = 1'b1; step("req2_next", pk(2, 1, 1, 0, 3, 7));
    key_next = 1'b0;

    key_confirm = 1'b1; Reset = 1'b1;
    #1;
    push_exp("async_rst", c_rst_vals);
    retire();
    step("rst_hold", c_rst_vals);
    Reset = 1'b0;
    step("no_done", c_rst_vals);
    key_confirm = 1'b0;
    step("rst_idle", c_rst_vals);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
